// File: rtl/spi_cnt4_reader.sv
// spi_cnt4_reader
// SPI master that reads the 4-bit counter stream from the FPGA-side SPI slave.
// It drives SSEL/SCK (CPOL=0), samples MISO on the first clk cycle of each SCK
// high phase, and rebuilds MSB-first nibbles. Every fifth SCK period is the
// slave's HiZ gap bit, which is clocked but never sampled. Each received nibble
// is compared with the expected sequence F,1,2,..,F,0,1,.. and mismatches are
// counted into a saturating 8-bit counter.
//
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   start, nibbles[7:0]  start pulse (ignored while busy), nibble count
//   SSEL, SCK, MOSI      SPI outputs (SSEL active low, SCK idles low, MOSI=0)
//   MISO                 SPI input from the slave
//   rx_data[3:0]         last received nibble, with rx_valid 1-cycle strobe
//   err_count[7:0]       mismatch count, cleared on each accepted start
//   busy, done           busy level and 1-cycle end-of-transfer pulse
module spi_cnt4_reader #(
  parameter int HALF_PERIOD = 8,
  parameter int LEAD        = 8,
  parameter int TRAIL       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] nibbles,
  output logic       SSEL,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic [3:0] rx_data,
  output logic       rx_valid,
  output logic [7:0] err_count,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ZERO, S_LEAD, S_SCK_LO, S_SCK_HI, S_TRAIL_LO, S_TRAIL_HI
  } state_t;

  localparam logic [15:0] HP_M1 = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] LD_M1 = 16'(LEAD - 1);
  localparam logic [15:0] TR_M1 = 16'(TRAIL - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;          // cycles spent in the current timed state
  logic [2:0]  bit_idx, bit_idx_n;  // 0..3 data bits, 4 = gap bit
  logic [7:0]  n_lat, n_lat_n;      // nibbles requested
  logic [7:0]  nib_idx, nib_idx_n;  // nibbles completed so far
  logic [3:0]  sreg, sreg_n;
  logic [3:0]  rx_data_n;
  logic        rx_valid_n;
  logic [7:0]  err_n;
  logic        busy_n, done_n, ssel_n, sck_n;
  logic [3:0]  shifted, exp_nib;

  assign MOSI    = 1'b0;
  assign shifted = {sreg[2:0], MISO};
  // First nibble of a transfer is F, nibble k after that is k mod 16.
  assign exp_nib = (nib_idx == 8'd0) ? 4'hF : nib_idx[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      n_lat     <= '0;
      nib_idx   <= '0;
      sreg      <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      SSEL      <= 1'b1;
      SCK       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      n_lat     <= n_lat_n;
      nib_idx   <= nib_idx_n;
      sreg      <= sreg_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      err_count <= err_n;
      busy      <= busy_n;
      done      <= done_n;
      SSEL      <= ssel_n;
      SCK       <= sck_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    n_lat_n    = n_lat;
    nib_idx_n  = nib_idx;
    sreg_n     = sreg;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    err_n      = err_count;
    busy_n     = busy;
    done_n     = 1'b0;
    ssel_n     = SSEL;
    sck_n      = SCK;

    case (state)
      S_IDLE: begin
        if (start) begin
          err_n  = '0;
          busy_n = 1'b1;
          if (nibbles != 8'd0) begin
            n_lat_n   = nibbles;
            nib_idx_n = '0;
            bit_idx_n = '0;
            cnt_n     = '0;
            ssel_n    = 1'b0;
            state_n   = S_LEAD;
          end else begin
            // Empty transfer: one busy cycle, then done, SSEL untouched.
            state_n = S_ZERO;
          end
        end
      end

      S_ZERO: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = S_IDLE;
      end

      S_LEAD: begin
        if (cnt == LD_M1) begin
          cnt_n   = '0;
          state_n = S_SCK_LO;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      S_SCK_LO: begin
        if (cnt == HP_M1) begin
          cnt_n   = '0;
          sck_n   = 1'b1;
          state_n = S_SCK_HI;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      S_SCK_HI: begin
        // MISO is taken raw: the slave holds it stable for a whole SCK
        // period, far longer than any metastability window here.
        if (cnt == 16'd0 && bit_idx != 3'd4) begin
          sreg_n = shifted;
          if (bit_idx == 3'd3) begin
            rx_data_n  = shifted;
            rx_valid_n = 1'b1;
            nib_idx_n  = nib_idx + 8'd1;
            if (shifted != exp_nib && err_count != 8'hFF)
              err_n = err_count + 8'd1;
          end
        end
        if (cnt == HP_M1) begin
          cnt_n = '0;
          sck_n = 1'b0;
          // The last nibble's gap bit is not clocked at all.
          if (bit_idx == 3'd3 && nib_idx == n_lat) begin
            state_n = S_TRAIL_LO;
          end else begin
            bit_idx_n = (bit_idx == 3'd4) ? 3'd0 : bit_idx + 3'd1;
            state_n   = S_SCK_LO;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      S_TRAIL_LO: begin
        if (cnt == TR_M1) begin
          cnt_n   = '0;
          ssel_n  = 1'b1;
          state_n = S_TRAIL_HI;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      S_TRAIL_HI: begin
        if (cnt == TR_M1) begin
          cnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_cnt4_reader.sv
// Bench for spi_cnt4_reader. Two instances share the clock: u0 with default
// timing (8/8/8) and u1 with HALF_PERIOD=LEAD=TRAIL=4. Each has a behavioural
// counter slave that shifts one bit per SCK falling edge after SSEL falls,
// 5 bits per nibble (4 data MSB first + gap). Slave modes: 0 = clean counter,
// 1 = bit 2 of one nibble flipped, 2 = every nibble inverted.
module tb_spi_cnt4_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = '0;
  logic [7:0] nib [2];
  logic [1:0] ssel, sck, mosi, miso, rxv, busy, done;
  logic [3:0] rxd [2];
  logic [7:0] errc [2];

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;
  int flipn   = 0;

  always #5 clk = ~clk;

  spi_cnt4_reader u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .nibbles(nib[0]),
    .SSEL(ssel[0]), .SCK(sck[0]), .MOSI(mosi[0]), .MISO(miso[0]),
    .rx_data(rxd[0]), .rx_valid(rxv[0]), .err_count(errc[0]),
    .busy(busy[0]), .done(done[0])
  );

  spi_cnt4_reader #(.HALF_PERIOD(4), .LEAD(4), .TRAIL(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .nibbles(nib[1]),
    .SSEL(ssel[1]), .SCK(sck[1]), .MOSI(mosi[1]), .MISO(miso[1]),
    .rx_data(rxd[1]), .rx_valid(rxv[1]), .err_count(errc[1]),
    .busy(busy[1]), .done(done[1])
  );

  // Nibble k as sent by the slave model.
  function automatic logic [3:0] sent(input int k, input int m, input int f);
    logic [3:0] v;
    v = (k == 0) ? 4'hF : 4'(k % 16);
    if (m == 1 && k == f) v = v ^ 4'b0100;
    if (m == 2) v = ~v;
    return v;
  endfunction

  function automatic logic slave_bit(input int p, input int m, input int f);
    logic [3:0] v;
    int b;
    b = p % 5;
    if (b == 4) return 1'b0;
    v = sent(p / 5, m, f);
    return v[3 - b];
  endfunction

  int   pos  [2];
  logic psck [2];
  for (genvar g = 0; g < 2; g++) begin : g_slv
    always @(posedge clk) begin
      psck[g] <= sck[g];
      if (ssel[g]) pos[g] <= 0;
      else if (psck[g] && !sck[g]) pos[g] <= pos[g] + 1;
    end
    assign miso[g] = slave_bit(pos[g], mode, flipn);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int inst;
    int n;
    int mode;
    int flipn;
    int exp_err;
    int exp_last;
    int poke;     // cycle after start at which a stray start is pulsed (0 = none)
  } vec_t;

  task automatic run_xfer(input vec_t v);
    int hp, ld, tr, k, kd, nv, nbusy, rises, run, bad, span;
    logic prev, fell;
    hp = (v.inst == 1) ? 4 : 8;
    ld = hp;
    tr = hp;
    mode  = v.mode;
    flipn = v.flipn;
    @(negedge clk);
    start[v.inst] = 1'b1;
    nib[v.inst]   = 8'(v.n);
    k = 0; kd = 0; nv = 0; nbusy = 0; rises = 0; run = 0; bad = 0;
    prev = sck[v.inst];
    fell = 1'b0;
    while (kd == 0 && k < 25000) begin
      @(negedge clk);
      k++;
      if (k == 1) start[v.inst] = 1'b0;
      if (v.poke != 0 && k == v.poke) begin
        start[v.inst] = 1'b1;
        nib[v.inst]   = 8'd9;
      end
      if (v.poke != 0 && k == v.poke + 1) start[v.inst] = 1'b0;
      if (rxv[v.inst]) begin
        chk("rx_nibble", int'(rxd[v.inst]), int'(sent(nv, v.mode, v.flipn)));
        nv++;
      end
      if (busy[v.inst]) nbusy++;
      if (!ssel[v.inst]) fell = 1'b1;
      if (sck[v.inst] != prev) begin
        if (prev && run != hp) bad++;
        if (!prev && rises > 0 && run != hp) bad++;
        if (!prev) rises++;
        prev = sck[v.inst];
        run  = 1;
      end else begin
        run++;
      end
      if (done[v.inst]) kd = k;
    end
    chk("done_seen", int'(kd != 0), 1);
    span = (v.n != 0) ? ld + (5 * v.n - 1) * 2 * hp + 2 * tr + 2 : 3;
    chk("span", kd + 1, span);
    chk("busy_cycles", nbusy, kd - 1);
    chk("busy_at_done", int'(busy[v.inst]), 0);
    chk("rx_count", nv, v.n);
    chk("err_count", int'(errc[v.inst]), v.exp_err);
    chk("rx_last", int'(rxd[v.inst]), v.exp_last);
    chk("sck_rises", rises, (v.n != 0) ? 5 * v.n - 1 : 0);
    chk("sck_phase", bad, 0);
    chk("ssel_fell", int'(fell), int'(v.n != 0));
    @(negedge clk);
    chk("done_pulse", int'(done[v.inst]), 0);
  endtask

  initial begin
    vec_t tbl [7];
    vec_t r;
    int k, nv;
    bit hit;

    //          inst  n   mode flip err  last poke
    tbl[0] = '{0,    4,   0,   0,   0,   3,   0};
    tbl[1] = '{0,    20,  0,   0,   0,   3,   0};
    tbl[2] = '{0,    4,   1,   3,   1,   7,   0};
    tbl[3] = '{0,    2,   0,   0,   0,   1,   100};
    tbl[4] = '{0,    255, 2,   0,   255, 1,   0};
    tbl[5] = '{0,    0,   0,   0,   0,   1,   0};
    tbl[6] = '{1,    3,   0,   0,   0,   2,   0};

    nib[0] = '0;
    nib[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ssel", int'(ssel[0]), 1);
    chk("rst_sck", int'(sck[0]), 0);
    chk("rst_mosi", int'(mosi[0]), 0);
    chk("rst_rx_data", int'(rxd[0]), 0);
    chk("rst_rx_valid", int'(rxv[0]), 0);
    chk("rst_err", int'(errc[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_xfer(tbl[i]);

    // Reset while nibble 2 is on the wire, during an SCK high phase.
    mode = 0;
    @(negedge clk);
    start[0] = 1'b1;
    nib[0]   = 8'd4;
    @(negedge clk);
    start[0] = 1'b0;
    k = 0; nv = 0; hit = 1'b0;
    while (!hit && k < 5000) begin
      @(negedge clk);
      k++;
      if (rxv[0]) nv++;
      if (nv == 2 && sck[0]) hit = 1'b1;
    end
    chk("reach_nibble2", int'(hit), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ssel", int'(ssel[0]), 1);
    chk("mid_rst_sck", int'(sck[0]), 0);
    chk("mid_rst_busy", int'(busy[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    r = '{0, 2, 0, 0, 0, 1, 0};
    run_xfer(r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
